apb_master_bridge: RTL



---
 rtl/apb_pkg.sv | 22 ++
 rtl/apb_wait_timer.sv | 30 +++
 rtl/apb_master_bridge.sv | 136 +++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared types and constants for the APB master bridge: FSM states, default
// widths and the sizing rule for the wait-state counter.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int unsigned APB_DATA_WIDTH = 32;
  localparam int unsigned APB_ADDR_WIDTH = 32;

  // Counter must hold 0..timeout; never narrower than one bit.
  function automatic int unsigned tmo_cnt_width(input int unsigned timeout_cycles);
    int unsigned w;
    w = $clog2(timeout_cycles + 1);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Counts PREADY-low ACCESS cycles and flags when the wait-state limit is
// reached. A limit of zero never expires.
module apb_wait_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CW             = 5
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [CW-1:0] TMO_LIM = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && !expired_o) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired_o = (TIMEOUT_CYCLES != 0) && (cnt_q == TMO_LIM);

endmodule

// File: rtl/apb_master_bridge.sv
// Valid/ready request/response to APB3 master bridge with back-to-back
// transfers and a wait-state timeout that aborts stuck ACCESS phases.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = APB_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH     = APB_ADDR_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_slverr,
  output logic                  rsp_timeout,
  output logic                  PSELx,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR,
  input  logic [DATA_WIDTH-1:0] PRDATA
);

  localparam int unsigned CW = tmo_cnt_width(TIMEOUT_CYCLES);

  apb_state_e            state_q;
  logic                  psel_q, penable_q, pwrite_q;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic [DATA_WIDTH-1:0] pwdata_q;
  logic                  rsp_valid_q, rsp_slverr_q, rsp_timeout_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;

  logic hs;
  logic tmo_expired;
  logic tmo_fire;

  // A pending response blocks acceptance unless it is drained this cycle.
  assign req_ready = !PRESET
                   && (state_q == IDLE || (state_q == ACCESS && PREADY))
                   && (!rsp_valid_q || rsp_ready);
  assign hs        = req_valid && req_ready;
  assign tmo_fire  = (state_q == ACCESS) && !PREADY && tmo_expired;

  apb_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CW            (CW)
  ) u_wait_timer (
    .clk_i    (PCLK),
    .rst_i    (PRESET),
    .clr_i    (state_q == SETUP),
    .en_i     ((state_q == ACCESS) && !PREADY),
    .expired_o(tmo_expired)
  );

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q       <= IDLE;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_slverr_q  <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      if (rsp_valid_q && rsp_ready) rsp_valid_q <= 1'b0;
      if (hs) begin
        paddr_q  <= req_addr;
        pwrite_q <= req_write;
        pwdata_q <= req_write ? req_wdata : '0;
      end
      case (state_q)
        IDLE: begin
          if (hs) begin
            state_q   <= SETUP;
            psel_q    <= 1'b1;
            penable_q <= 1'b0;
          end
        end
        SETUP: begin
          state_q   <= ACCESS;
          penable_q <= 1'b1;
        end
        ACCESS: begin
          if (PREADY) begin
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= pwrite_q ? '0 : PRDATA;
            rsp_slverr_q  <= PSLVERR;
            rsp_timeout_q <= 1'b0;
            penable_q     <= 1'b0;
            if (hs) begin
              state_q <= SETUP;
            end else begin
              state_q <= IDLE;
              psel_q  <= 1'b0;
            end
          end else if (tmo_fire) begin
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= '0;
            rsp_slverr_q  <= 1'b1;
            rsp_timeout_q <= 1'b1;
            state_q       <= IDLE;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
        end
      endcase
    end
  end

  assign PSELx       = psel_q;
  assign PENABLE     = penable_q;
  assign PWRITE      = pwrite_q;
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_slverr  = rsp_slverr_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule
